serial_read_buffer: RTL and testbench

//  Serial-in/parallel-out capture buffer; receive-side counterpart of the serial write buffer.

---
 rtl/serial_buf_pkg.sv | 24 ++
 rtl/serial_read_buffer.sv | 93 +++++++++
 tb/tb_serial_read_buffer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/serial_buf_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : serial_buf_pkg
// Brief  : Shared state encodings and count-width helper for the serial
//          read/write buffers.
// Rev    : 1.0  initial release
// ============================================================================
package serial_buf_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam int c_DEFAULT_BUF_SIZE = 8;

    // Wide enough to hold the full transfer length, not just the last index.
    function automatic int count_width(input int buf_size);
        return $clog2(buf_size + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_read_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : serial_read_buffer
// Brief  : Serial-in/parallel-out capture buffer with a left-justified result.
//          SERIAL_READ_BUF_LSB_FIRST_EN selects LSB-first bit placement.
// Rev    : 1.0  initial release
// ============================================================================
module serial_read_buffer
    import serial_buf_pkg::*;
#(
    parameter int BUF_SIZE        = c_DEFAULT_BUF_SIZE,
    parameter int READ_COUNT_SIZE = count_width(BUF_SIZE)
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       read_sig,
    input  logic                       data_in,
    input  logic [READ_COUNT_SIZE-1:0] read_count,
    output logic [BUF_SIZE-1:0]        data_out,
    output logic                       done_sig
);

    localparam int                         c_IDX_W    = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
    localparam logic [READ_COUNT_SIZE-1:0] c_BUF_SIZE = READ_COUNT_SIZE'(BUF_SIZE);
    localparam logic [READ_COUNT_SIZE-1:0] c_ONE      = READ_COUNT_SIZE'(1);

    state_t                     r_state, w_state_nxt;
    logic [READ_COUNT_SIZE-1:0] r_n, w_n_nxt;
    logic [READ_COUNT_SIZE-1:0] r_cnt, w_cnt_nxt;
    logic [READ_COUNT_SIZE-1:0] w_cnt_inc;
    logic [READ_COUNT_SIZE-1:0] w_n_clamped;
    logic [BUF_SIZE-1:0]        r_data, w_data_nxt;
    logic [c_IDX_W-1:0]         w_idx;

    assign w_n_clamped = (read_count > c_BUF_SIZE) ? c_BUF_SIZE : read_count;
    assign w_cnt_inc   = r_cnt + c_ONE;

`ifdef SERIAL_READ_BUF_LSB_FIRST_EN
    // First bit lands at the bottom of the justified field.
    assign w_idx = c_IDX_W'(c_BUF_SIZE - r_n + r_cnt);
`else
    assign w_idx = c_IDX_W'(c_BUF_SIZE - c_ONE - r_cnt);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        case (r_state)
            IDLE: begin
                // A strobe coinciding with start is dropped: capture begins next cycle.
                if (start && (read_count != '0)) begin
                    w_state_nxt = READ;
                    w_n_nxt     = w_n_clamped;
                    w_cnt_nxt   = '0;
                    w_data_nxt  = '0;
                end
            end
            READ: begin
                if (read_sig) begin
                    w_data_nxt[w_idx] = data_in;
                    w_cnt_nxt         = w_cnt_inc;
                    if (w_cnt_inc == r_n) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign data_out = r_data;
    assign done_sig = (r_state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_read_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_serial_read_buffer
// Brief  : Directed self-checking bench for serial_read_buffer (12 MHz clock,
//          one read strobe every 8 clocks).
// Rev    : 1.0  initial release
// ============================================================================
module tb_serial_read_buffer;

    logic       sys_clk    = 1'b0;
    logic       rst        = 1'b1;
    logic       start      = 1'b0;
    logic       read_sig   = 1'b0;
    logic       data_in    = 1'b0;
    logic [3:0] read_count = 4'd0;
    logic [7:0] data_out;
    logic       done_sig;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

`ifdef SERIAL_READ_BUF_LSB_FIRST_EN
    localparam logic [7:0] c_E1  = 8'h39;
    localparam logic [7:0] c_E2  = 8'h3C;
    localparam logic [7:0] c_E4  = 8'hA0;
    localparam logic [7:0] c_E5  = 8'h53;
    localparam logic [7:0] c_E6A = 8'h9C;
    localparam logic [7:0] c_E6B = 8'h50;
`else
    localparam logic [7:0] c_E1  = 8'h9C;
    localparam logic [7:0] c_E2  = 8'hF0;
    localparam logic [7:0] c_E4  = 8'h50;
    localparam logic [7:0] c_E5  = 8'hCA;
    localparam logic [7:0] c_E6A = 8'h39;
    localparam logic [7:0] c_E6B = 8'hA0;
`endif

    serial_read_buffer #(
        .BUF_SIZE        (8),
        .READ_COUNT_SIZE (4)
    ) u_dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .start      (start),
        .read_sig   (read_sig),
        .data_in    (data_in),
        .read_count (read_count),
        .data_out   (data_out),
        .done_sig   (done_sig)
    );

    always #41.666 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [3:0] n, input logic with_strobe);
        @(negedge sys_clk);
        start      = 1'b1;
        read_count = n;
        read_sig   = with_strobe;
        data_in    = 1'b1;
        @(negedge sys_clk);
        start      = 1'b0;
        read_sig   = 1'b0;
    endtask

    task automatic do_strobe(input logic b);
        repeat (7) @(negedge sys_clk);
        data_in  = b;
        read_sig = 1'b1;
        @(negedge sys_clk);
        read_sig = 1'b0;
    endtask

    // seq[7] is the first bit on the line; restart_at re-pulses start before that strobe.
    task automatic xfer(input string tag, input logic [3:0] n, input int nstb,
                        input logic [7:0] seq, input logic [7:0] exp,
                        input int restart_at, input logic with_strobe);
        exp_q.push_back(exp);
        do_start(n, with_strobe);
        check({tag, "_busy"}, {7'b0, done_sig}, 8'h00);
        for (int i = 0; i < nstb; i++) begin
            if (i == restart_at) begin
                @(negedge sys_clk);
                start      = 1'b1;
                read_count = 4'd8;
                @(negedge sys_clk);
                start      = 1'b0;
                check({tag, "_restart_busy"}, {7'b0, done_sig}, 8'h00);
            end
            do_strobe(seq[7-i]);
            if (i < nstb - 1) begin
                check({tag, "_low"}, {7'b0, done_sig}, 8'h00);
            end
        end
        check({tag, "_done"}, {7'b0, done_sig}, 8'h01);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 8'h01, 8'h00);
        end else begin
            check({tag, "_data"}, data_out, exp_q.pop_front());
        end
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge sys_clk);
        check("reset_done", {7'b0, done_sig}, 8'h01);
        check("reset_data", data_out, 8'h00);
        rst = 1'b0;

        // Full-width and partial transfers
        xfer("t1_n8", 4'd8, 8, 8'b1001_1100, c_E1, -1, 1'b0);
        xfer("t2_n6", 4'd6, 6, 8'b1111_0000, c_E2, -1, 1'b0);

        // Reset part way through a transfer
        do_start(4'd6, 1'b0);
        for (int i = 0; i < 3; i++) do_strobe(1'b1);
        check("t3_busy", {7'b0, done_sig}, 8'h00);
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        check("t3_rst_done", {7'b0, done_sig}, 8'h01);
        check("t3_rst_data", data_out, 8'h00);
        for (int i = 0; i < 3; i++) do_strobe(1'b1);
        check("t3_after_done", {7'b0, done_sig}, 8'h01);
        check("t3_after_data", data_out, 8'h00);

        // Start re-pulsed mid-transfer must be ignored
        xfer("t4_n4", 4'd4, 4, 8'b0101_0000, c_E4, 2, 1'b0);

        // Zero-length start is ignored; strobes in IDLE are ignored
        do_start(4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t5_n0_done", {7'b0, done_sig}, 8'h01);
            @(negedge sys_clk);
        end
        check("t5_n0_data", data_out, c_E4);
        do_strobe(1'b1);
        check("t5_idle_strobe_data", data_out, c_E4);

        // Oversized count clamps to 8; strobe coincident with start is dropped
        xfer("t5_n12", 4'd12, 8, 8'b1100_1010, c_E5, -1, 1'b1);

        // Bit-order vectors
        xfer("t6_n8", 4'd8, 8, 8'b0011_1001, c_E6A, -1, 1'b0);
        xfer("t6_n4", 4'd4, 4, 8'b1010_0000, c_E6B, -1, 1'b0);

        check("sb_empty", 8'(exp_q.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
